// File: rtl/mips_shift_pkg.sv
// Shared constants and FSM state encoding for the sequential right-shift unit.
package mips_shift_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One-bit right shift with an externally supplied MSB fill bit (purely combinational).
module shift_right_step #(
    parameter int WIDTH = mips_shift_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    assign q = {fill, d[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle right shifter: one bit per cycle, logical or arithmetic, latency N+1.
module shift_right_unit #(
    parameter int WIDTH = mips_shift_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         in,
    input  logic [$clog2(WIDTH)-1:0] shiftAmmount,
    input  logic                     arith,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         out
);

    localparam int                 SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    mips_shift_pkg::state_t state_q, state_d;

    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   step_out;
    logic               fill_q;
    logic               accept;
    logic               last_step;

    // A new request is only taken when nothing is in flight; DONE counts as free.
    assign accept    = start && (state_q != mips_shift_pkg::SHIFT);
    assign last_step = (state_q == mips_shift_pkg::SHIFT) && (cnt_q == CNT_ONE);

    assign busy = (state_q == mips_shift_pkg::SHIFT);
    assign done = (state_q == mips_shift_pkg::DONE);

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .d    (work_q),
        .fill (fill_q),
        .q    (step_out)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= mips_shift_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            mips_shift_pkg::IDLE,
            mips_shift_pkg::DONE: begin
                if (start) begin
                    state_d = (shiftAmmount == '0) ? mips_shift_pkg::DONE
                                                   : mips_shift_pkg::SHIFT;
                end else begin
                    state_d = mips_shift_pkg::IDLE;
                end
            end
            mips_shift_pkg::SHIFT: begin
                if (last_step) state_d = mips_shift_pkg::DONE;
            end
            default: state_d = mips_shift_pkg::IDLE;
        endcase
    end

    // Fill bit is fixed at accept: sign of the operand for arithmetic, zero for logical.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            work_q <= '0;
            fill_q <= 1'b0;
            out    <= '0;
        end else if (accept) begin
            cnt_q  <= shiftAmmount;
            work_q <= in;
            fill_q <= arith & in[WIDTH-1];
            if (shiftAmmount == '0) out <= in;
        end else if (state_q == mips_shift_pkg::SHIFT) begin
            cnt_q  <= cnt_q - CNT_ONE;
            work_q <= step_out;
            if (last_step) out <= step_out;
        end
    end

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed self-checking bench for shift_right_unit: latency, busy window, fill modes, reset abort.
module tb_shift_right_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] din;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    shift_right_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in           (din),
        .shiftAmmount (shamt),
        .arith        (arith),
        .busy         (busy),
        .done         (done),
        .out          (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request through accept edge T, then scramble the operands to prove they were latched.
    task automatic launch(input logic [31:0] d, input logic [4:0] n, input logic ar);
        start = 1'b1;
        din   = d;
        shamt = n;
        arith = ar;
        tick();
        start = 1'b0;
        din   = ~d;
        shamt = ~n;
        arith = ~ar;
    endtask

    // Full operation: busy for exactly N cycles, done at T+N+1 with the expected result, then idle.
    task automatic do_op(input string name, input logic [31:0] d, input logic [4:0] n,
                         input logic ar, input logic [31:0] exp);
        launch(d, n, ar);
        for (int i = 1; i <= int'(n); i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s busy@T+%0d: busy=%b done=%b, required busy=1 done=0", name, i, busy, done);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done@T+%0d: busy=%b done=%b, required busy=0 done=1", name, int'(n) + 1, busy, done);
        end
        n_cmp++;
        if (dout !== exp) begin
            n_bad++;
            $display("FAIL %s result: out=%h, required %h", name, dout, exp);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || dout !== exp) begin
            n_bad++;
            $display("FAIL %s after_done: busy=%b done=%b out=%h, required 0 0 %h", name, busy, done, dout, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        din   = 32'hA5A5_A5A5;
        shamt = 5'd3;
        arith = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, dout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, dout);
        end
    endtask

    task automatic test_logical();
        do_op("logical_n4", 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000);
        do_op("logical_n31", 32'hDEAD_BEEF, 5'd31, 1'b0, 32'h0000_0001);
        do_op("logical_n1", 32'hFFFF_FFFF, 5'd1, 1'b0, 32'h7FFF_FFFF);
    endtask

    task automatic test_arith();
        do_op("arith_n4", 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
        do_op("arith_pos_n31", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);
        do_op("arith_n7", 32'h9234_5678, 5'd7, 1'b1, 32'hFF24_68AC);
    endtask

    task automatic test_zero_shift();
        do_op("zero_shift", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678);
    endtask

    task automatic test_ignore_start();
        launch(32'h8000_0000, 5'd31, 1'b1);
        for (int i = 1; i <= 31; i++) begin
            if (i == 10) begin
                start = 1'b1;
                din   = 32'h0;
                shamt = 5'd0;
                arith = 1'b0;
            end
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL ignore_start busy@T+%0d: busy=%b done=%b, required 1 0", i, busy, done);
            end
            tick();
            start = 1'b0;
        end
        n_cmp++;
        if (done !== 1'b1 || dout !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL ignore_start result: done=%b out=%h, required 1 ffffffff", done, dout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        launch(32'hF000_0000, 5'd2, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (done !== 1'b1 || dout !== 32'hFC00_0000) begin
            n_bad++;
            $display("FAIL b2b_first: done=%b out=%h, required 1 fc000000", done, dout);
        end
        launch(32'h0000_00F0, 5'd4, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || dout !== 32'hFC00_0000) begin
                n_bad++;
                $display("FAIL b2b_second@T+%0d: busy=%b done=%b out=%h, required 1 0 fc000000", i, busy, done, dout);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || dout !== 32'h0000_000F) begin
            n_bad++;
            $display("FAIL b2b_result: done=%b out=%h, required 1 0000000f", done, dout);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int seen_done;
        launch(32'hFFFF_0000, 5'd8, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || dout !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_async: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, dout);
        end
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
            tick();
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: active cycles=%0d, required 0", seen_done);
        end
        do_op("after_abort", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_zero_shift();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
